// File: rtl/logic_unit_scheduler.sv
// Round-robin scheduler that serialises NREQ requesters onto one registered
// multi-function logic unit. Each transaction goes accept -> execute -> respond.
module logic_unit_scheduler #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [3*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int unsigned IDW  = $clog2(NREQ);
  localparam int unsigned IDW1 = IDW + 1;
  localparam int unsigned OPW  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [IDW-1:0]   rr_ptr;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDW-1:0]   id_q;

  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  logic [IDW:0]     idx_sum;
  logic [IDW-1:0]   idx;
  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] alu_data;
  logic             alu_err;
  logic [IDW:0]     id_inc;
  logic [IDW-1:0]   rr_next;

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx_sum     = '0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_sum = IDW1'(rr_ptr) + IDW1'(k);
      if (idx_sum >= IDW1'(NREQ)) begin
        idx_sum = idx_sum - IDW1'(NREQ);
      end
      idx = IDW'(idx_sum);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  // Next state, request acceptance and response completion
  always_comb begin
    state_d   = state;
    req_ready = '0;
    accept    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_id] = 1'b1;
          accept              = 1'b1;
          state_d             = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Logic unit operating on the captured operands
  always_comb begin
    alu_data = '0;
    alu_err  = 1'b0;
    case (op_q)
      3'b000:  alu_data = a_q & b_q;
      3'b001:  alu_data = a_q | b_q;
      3'b010:  alu_data = a_q ^ b_q;
      3'b011:  alu_data = ~(a_q & b_q);
      3'b100:  alu_data = ~(a_q | b_q);
      3'b101:  alu_data = ~(a_q ^ b_q);
      3'b110:  alu_data = ~a_q;
      default: begin
        alu_data = '0;
        alu_err  = 1'b1;
      end
    endcase
  end

  // Pointer moves just past the requester whose response completed
  always_comb begin
    id_inc  = IDW1'(rsp_id) + IDW1'(1);
    rr_next = IDW'(id_inc);
    if (id_inc >= IDW1'(NREQ)) begin
      rr_next = '0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Operand capture, response registers and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= req_op[grant_id*OPW +: OPW];
        a_q  <= req_a[grant_id*WIDTH +: WIDTH];
        b_q  <= req_b[grant_id*WIDTH +: WIDTH];
        id_q <= grant_id;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_data  <= alu_data;
        rsp_err   <= alu_err;
      end
      if (complete) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= rr_next;
      end
    end
  end

  // Busy whenever a transaction is in flight
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Directed bench for logic_unit_scheduler with hand-computed expectations.
module tb_logic_unit_scheduler;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDW   = 2;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [3*NREQ-1:0]       req_op;
  logic [WIDTH*NREQ-1:0]   req_a;
  logic [WIDTH*NREQ-1:0]   req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [WIDTH-1:0]        rsp_data;
  logic                    rsp_err;
  logic                    busy;

  int errors = 0;
  int checks = 0;

  logic [IDW-1:0]   hold_id;
  logic [WIDTH-1:0] hold_data;
  logic [NREQ-1:0]  exp_ready;

  logic_unit_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[3*i +: 3]         = op;
    req_a[WIDTH*i +: WIDTH]  = a;
    req_b[WIDTH*i +: WIDTH]  = b;
  endtask

  // One full transaction from a single requester with rsp_ready held high
  task automatic do_txn(input string tag, input int i, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_data, input logic exp_err);
    set_req(i, op, a, b);
    req_valid = NREQ'(1) << i;
    rsp_ready = 1'b1;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(NREQ'(1) << i));
    tick();
    req_valid = '0;
    #1;
    chk({tag, "_exec_busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(i));
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_data));
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
    tick();
    chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // Single AND request, then backpressure in RESP
    set_req(0, 3'b000, 8'hF0, 8'h3C);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    chk("t1_exec_valid", 32'(rsp_valid), 32'd0);
    chk("t1_exec_ready", 32'(req_ready), 32'd0);
    chk("t1_exec_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_id", 32'(rsp_id), 32'd0);
    chk("t1_rsp_data", 32'(rsp_data), 32'h30);
    chk("t1_rsp_err", 32'(rsp_err), 32'd0);
    req_valid = 4'b0110;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t3_hold_id", 32'(rsp_id), 32'd0);
      chk("t3_hold_data", 32'(rsp_data), 32'h30);
      chk("t3_hold_ready", 32'(req_ready), 32'd0);
      chk("t3_hold_busy", 32'(busy), 32'd1);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    chk("t3_release_valid", 32'(rsp_valid), 32'd0);
    chk("t3_release_busy", 32'(busy), 32'd0);
    rsp_ready = 1'b0;

    // Reset returns rr_ptr to 0 before the round-robin sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // All four requesters valid: grants 0,1,2,3, accepts 3 cycles apart
    set_req(0, 3'b001, 8'hA5, 8'h0F);
    set_req(1, 3'b010, 8'hA5, 8'h0F);
    set_req(2, 3'b011, 8'hA5, 8'h0F);
    set_req(3, 3'b101, 8'hA5, 8'h0F);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      exp_ready = NREQ'(1) << g;
      chk("t2_grant", 32'(req_ready), 32'(exp_ready));
      tick();
      req_valid[g] = 1'b0;
      #1;
      chk("t2_exec_ready", 32'(req_ready), 32'd0);
      tick();
      chk("t2_resp_ready", 32'(req_ready), 32'd0);
      chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t2_rsp_id", 32'(rsp_id), 32'(g));
      case (g)
        0: hold_data = 8'hAF;
        1: hold_data = 8'hAA;
        2: hold_data = 8'hFA;
        default: hold_data = 8'h55;
      endcase
      chk("t2_rsp_data", 32'(rsp_data), 32'(hold_data));
      tick();
    end
    chk("t2_end_valid", 32'(rsp_valid), 32'd0);

    // NOT and illegal opcodes (rr_ptr wrapped back to 0)
    do_txn("t4_not", 0, 3'b110, 8'h0F, 8'hAA, 8'hF0, 1'b0);
    do_txn("t4_ill", 1, 3'b111, 8'h0F, 8'hAA, 8'h00, 1'b1);
    do_txn("t4_nor", 2, 3'b100, 8'hA5, 8'h0F, 8'h50, 1'b0);

    // Reset during EXEC drops the transaction
    set_req(3, 3'b000, 8'hFF, 8'hFF);
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    #1;
    chk("t5_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("t5_exec_busy", 32'(busy), 32'd1);
    tick();
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Requesters 1 and 3 held valid: grants alternate 1,3,1,3
    for (int i = 0; i < 4; i++) set_req(i, 3'b010, 8'(8'h10 * i), 8'h00);
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      hold_id = (g % 2 == 0) ? 2'd1 : 2'd3;
      #1;
      exp_ready = NREQ'(1) << hold_id;
      chk("t6_grant", 32'(req_ready), 32'(exp_ready));
      tick();
      tick();
      chk("t6_rsp_id", 32'(rsp_id), 32'(hold_id));
      chk("t6_rsp_data", 32'(rsp_data), 32'(8'h10) * 32'(hold_id));
      tick();
    end
    req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
